difftest_irp_event_gen: RTL and testbench
=========================================

// Module: difftest_irp_event_gen
// PURPOSE
//  Upstream producer for the difftest non-register interrupt-pending event sink.
//  - Samples the platform/AIA/local-counter interrupt-pending wires.
//  - Detects changes against the last queued snapshot and buffers changed snapshots in a small FIFO.
//  - Releases one event per retire-boundary cycle as the enable/io_valid strobe plus payload.
//  - Output drives the DPI sink directly. The DPI sink has no backpressure, so loss is counted, never stalled.
// PARAMETERS
//  DEPTH     4   FIFO entries, power of two, >=2
//  CNT_W     16  width of saturating drop counter
// PORTS
//  clock            input   1      core clock
//  reset            input   1      asynchronous, active-low reset (0 = in reset)
//  in_irp           input   10     raw pending bits {lcofi,aia_seip,aia_meip,vstip,vseip,stip,seip,msip,mtip,meip}
//  in_coreid        input   8      hart id, quasi-static
//  commit_valid     input   1      an instruction retires this cycle; events may only be emitted on these cycles
//  force_report     input   1      enqueue current snapshot even if unchanged (one-cycle pulse)
//  out_enable       output  1      one-cycle strobe to sink enable
//  out_valid        output  1      equal to out_enable
//  out_irp          output  10     payload bits, same order as in_irp
//  out_coreid       output  8      registered in_coreid
//  drop_count       output  CNT_W  number of coalesced (overwritten) snapshots, saturating
//  fifo_empty       output  1      FIFO occupancy == 0
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - sample, last_q, FIFO pointers/count, out_* and drop_count all go to 0; fifo_empty=1.
//  Sample stage:
//  - sample <= in_irp every cycle.
//  Push request:
//  - push = (sample != last_q) | force_report_q, where force_report_q is force_report registered once.
//  - On push, last_q <= sample.
//  - The first nonzero sample after reset is therefore reported.
//  Pop:
//  - pop = commit_valid & !empty. At most one pop per cycle.
//  - On pop: out_enable=out_valid=1 for one cycle with out_irp=head; otherwise out_enable=out_valid=0.
//  - out_irp holds the last popped value when idle.
//  FIFO:
//  - Circular buffer; pointers wrap modulo DEPTH; count is 0..DEPTH.
//  - push & !full: write at tail, tail++.
//  - push & full & !pop: coalesce. Overwrite the newest entry (tail-1) with sample. Count unchanged. drop_count++ (saturates at all-ones).
//  - push & full & pop: normal push and pop. No drop.
//  - push & pop & empty: no bypass. The entry becomes visible next cycle.
//  - push & pop, not empty and not full: count unchanged, both pointers advance.
//  Latency:
//  - in_irp change before edge 0 is sampled at edge 0 and enqueued at edge 1.
//  - out_valid is high in the cycle after edge 2, if commit_valid=1 in the cycle before edge 2.
//  - Minimum latency is 2 cycles. The output is held in the FIFO until commit_valid.
//  Ordering:
//  - Events are emitted strictly in push order.
//  - A coalesced entry keeps its FIFO position and carries only the newest value.
//  Reset mid-operation:
//  - All queued events are discarded. Nothing is emitted until a new push is popped.
//  Other:
//  - out_coreid <= in_coreid every cycle.
//  - Module contains no DPI calls; it is synthesizable.
// TESTING
//  1 Reset, in_irp=0, commit_valid=1 for 20 cycles -> out_valid never asserts; fifo_empty=1; drop_count=0.
//  2 in_irp=10'h001 at cycle 5, commit_valid=1 always -> exactly one out_valid pulse 2 cycles later, out_irp=10'h001.
//  3 commit_valid=0; in_irp steps 001,002,004,008,010,020 on consecutive cycles (DEPTH=4), then commit_valid=1
//    -> 4 pulses, payloads 001,002,004,020; drop_count=2.
//  4 FIFO full, same cycle push (in_irp=10'h3FF) and commit_valid=1 -> no drop; count stays 4; 3FF emitted last.
//  5 force_report pulse with unchanged in_irp=10'h005, commit_valid=1 -> one pulse, out_irp=10'h005; no pulse without force.
//  6 Three entries queued, reset asserted mid-cycle for 1 cycle -> outputs immediately 0; after release no pulses until a new in_irp change.

Source files
------------

// File: rtl/difftest_irp_event_gen.sv
// Interrupt-pending event producer for the difftest sink: snapshots the pending wires,
// queues changed snapshots and releases one per retire cycle, coalescing on overflow.
module difftest_irp_event_gen #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0]       in_irp,
  input  logic [7:0]       in_coreid,
  input  logic             commit_valid,
  input  logic             force_report,
  output logic             out_enable,
  output logic             out_valid,
  output logic [9:0]       out_irp,
  output logic [7:0]       out_coreid,
  output logic [CNT_W-1:0] drop_count,
  output logic             fifo_empty
);

  localparam int unsigned IRP_W = 10;
  localparam int unsigned ID_W  = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [IRP_W-1:0] sample_q;
  logic             force_q;
  logic [IRP_W-1:0] last_q, last_d;
  logic [IRP_W-1:0] mem_q [DEPTH];
  logic [IRP_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             out_en_q, out_en_d;
  logic [IRP_W-1:0] out_irp_q, out_irp_d;
  logic [ID_W-1:0]  coreid_q;
  logic             empty_q, empty_d;

  logic push_c;
  logic pop_c;
  logic full_c;
  logic empty_c;
  logic write_c;

  // Queue control: change detection, pop on retire, coalesce into newest entry when full
  always_comb begin
    last_d    = last_q;
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    drop_d    = drop_q;
    out_irp_d = out_irp_q;

    empty_c = (occ_q == '0);
    full_c  = (occ_q == OCC_FULL);
    push_c  = (sample_q != last_q) | force_q;
    pop_c   = commit_valid & ~empty_c;
    write_c = push_c & (~full_c | pop_c);
    out_en_d = pop_c;

    if (push_c) begin
      last_d = sample_q;
    end

    if (pop_c) begin
      out_irp_d = mem_q[head_q];
      head_d    = head_q + PTR_W'(1);
    end

    if (write_c) begin
      mem_d[tail_q] = sample_q;
      tail_d        = tail_q + PTR_W'(1);
    end else if (push_c) begin
      // Full and nothing leaving: the newest entry absorbs the snapshot, loss is counted
      mem_d[tail_q - PTR_W'(1)] = sample_q;
      if (drop_q != '1) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end

    if (write_c && !pop_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop_c && !write_c) begin
      occ_d = occ_q - OCC_W'(1);
    end

    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_q  <= '0;
      force_q   <= 1'b0;
      last_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      drop_q    <= '0;
      out_en_q  <= 1'b0;
      out_irp_q <= '0;
      coreid_q  <= '0;
      empty_q   <= 1'b1;
    end else begin
      sample_q  <= in_irp;
      force_q   <= force_report;
      last_q    <= last_d;
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      drop_q    <= drop_d;
      out_en_q  <= out_en_d;
      out_irp_q <= out_irp_d;
      coreid_q  <= in_coreid;
      empty_q   <= empty_d;
    end
  end

  assign out_enable = out_en_q;
  assign out_valid  = out_en_q;
  assign out_irp    = out_irp_q;
  assign out_coreid = coreid_q;
  assign drop_count = drop_q;
  assign fifo_empty = empty_q;

endmodule

// File: tb/tb_difftest_irp_event_gen.sv
// Directed bench for difftest_irp_event_gen: latency, coalescing, full push+pop, force, reset.
module tb_difftest_irp_event_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  in_irp;
  logic [7:0]  in_coreid;
  logic        commit_valid;
  logic        force_report;
  logic        out_enable;
  logic        out_valid;
  logic [9:0]  out_irp;
  logic [7:0]  out_coreid;
  logic [15:0] drop_count;
  logic        fifo_empty;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] got[$];
  int first_idx;
  logic [9:0] seq3 [6] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020};
  logic [9:0] exp3 [4] = '{10'h001, 10'h002, 10'h004, 10'h020};
  logic [9:0] exp4 [5] = '{10'h011, 10'h012, 10'h013, 10'h014, 10'h3FF};

  always #5 clock = ~clock;

  difftest_irp_event_gen #(.DEPTH(4), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_irp       (in_irp),
    .in_coreid    (in_coreid),
    .commit_valid (commit_valid),
    .force_report (force_report),
    .out_enable   (out_enable),
    .out_valid    (out_valid),
    .out_irp      (out_irp),
    .out_coreid   (out_coreid),
    .drop_count   (drop_count),
    .fifo_empty   (fifo_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run n cycles, recording every emitted payload and the cycle of the first pulse
  task automatic collect(input int n);
    got.delete();
    first_idx = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (out_enable === 1'b1) begin
        chk("valid_eq_enable", 32'(out_valid), 32'(1));
        got.push_back(out_irp);
        if (first_idx == 0) first_idx = i;
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    in_irp       = '0;
    in_coreid    = 8'hA5;
    commit_valid = 1'b0;
    force_report = 1'b0;
    #12;
    chk("rst_enable", 32'(out_enable), 32'(0));
    chk("rst_empty",  32'(fifo_empty), 32'(1));
    chk("rst_drop",   32'(drop_count), 32'(0));
    chk("rst_irp",    32'(out_irp),    32'(0));
    chk("rst_coreid", 32'(out_coreid), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("coreid", 32'(out_coreid), 32'(8'hA5));

    // Idle with retires: nothing to report
    commit_valid = 1'b1;
    collect(20);
    chk("t1_npulse", 32'(got.size()), 32'(0));
    chk("t1_empty",  32'(fifo_empty), 32'(1));
    chk("t1_drop",   32'(drop_count), 32'(0));

    // Single change: visible on the third edge after the input moves
    in_irp = 10'h001;
    collect(6);
    chk("t2_npulse", 32'(got.size()), 32'(1));
    chk("t2_latency", 32'(first_idx), 32'(3));
    if (got.size() > 0) chk("t2_payload", 32'(got[0]), 32'(10'h001));
    chk("t2_hold", 32'(out_irp), 32'(10'h001));
    chk("t2_empty", 32'(fifo_empty), 32'(1));

    in_irp = 10'h000;
    collect(5);
    chk("prep_npulse", 32'(got.size()), 32'(1));
    if (got.size() > 0) chk("prep_payload", 32'(got[0]), 32'(10'h000));

    // Six changes into four entries with no retires: last two coalesce
    commit_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_irp = seq3[i];
      tick();
    end
    repeat (3) tick();
    chk("t3_drop",   32'(drop_count), 32'(2));
    chk("t3_empty",  32'(fifo_empty), 32'(0));
    chk("t3_enable", 32'(out_enable), 32'(0));
    commit_valid = 1'b1;
    collect(8);
    chk("t3_npulse", 32'(got.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("t3_payload", 32'(got[i]), 32'(exp3[i]));
    end
    chk("t3_empty_after", 32'(fifo_empty), 32'(1));

    // Fill to full, then push and pop on the same edge: no drop
    commit_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_irp = exp4[i];
      tick();
    end
    repeat (3) tick();
    chk("t4_drop_full", 32'(drop_count), 32'(2));
    in_irp = 10'h3FF;
    tick();
    commit_valid = 1'b1;
    collect(10);
    chk("t4_npulse", 32'(got.size()), 32'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("t4_payload", 32'(got[i]), 32'(exp4[i]));
    end
    chk("t4_drop", 32'(drop_count), 32'(2));

    // Forced report of an unchanged snapshot
    in_irp = 10'h005;
    collect(5);
    chk("t5_change_npulse", 32'(got.size()), 32'(1));
    collect(6);
    chk("t5_quiet_npulse", 32'(got.size()), 32'(0));
    force_report = 1'b1;
    tick();
    force_report = 1'b0;
    collect(6);
    chk("t5_force_npulse", 32'(got.size()), 32'(1));
    if (got.size() > 0) chk("t5_force_payload", 32'(got[0]), 32'(10'h005));

    // Reset with events queued and one in flight
    commit_valid = 1'b0;
    in_irp = 10'h101; tick();
    in_irp = 10'h102; tick();
    in_irp = 10'h103; tick();
    repeat (3) tick();
    chk("t6_empty_pre", 32'(fifo_empty), 32'(0));
    commit_valid = 1'b1;
    tick();
    chk("t6_enable_pre", 32'(out_enable), 32'(1));
    chk("t6_irp_pre",    32'(out_irp),    32'(10'h101));
    #2;
    reset  = 1'b0;
    in_irp = 10'h000;
    #1;
    chk("t6_rst_enable", 32'(out_enable), 32'(0));
    chk("t6_rst_valid",  32'(out_valid),  32'(0));
    chk("t6_rst_irp",    32'(out_irp),    32'(0));
    chk("t6_rst_empty",  32'(fifo_empty), 32'(1));
    chk("t6_rst_drop",   32'(drop_count), 32'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    collect(10);
    chk("t6_post_npulse", 32'(got.size()), 32'(0));
    in_irp = 10'h2AA;
    collect(6);
    chk("t6_new_npulse", 32'(got.size()), 32'(1));
    if (got.size() > 0) chk("t6_new_payload", 32'(got[0]), 32'(10'h2AA));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
